rr_arbiter4: RTL and testbench



---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_arbiter4_chk.sv | 18 +
 rtl/rr_pick.sv | 46 ++++
 rtl/rr_arbiter4.sv | 126 ++++++++++++
 tb/tb_rr_arbiter4.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

  localparam int NREQ = 4;
  localparam int IW   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] idx2oh(input logic [IW-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_chk.sv
// Structural invariants of the arbiter outputs.
module rr_arbiter4_chk
  import arb_pkg::*;
(
  input logic            clk,
  input logic            reset,
  input logic [NREQ-1:0] gnt,
  input logic [IW-1:0]   gnt_idx,
  input logic            gnt_valid,
  input logic            timeout
);

  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_valid:  assert property (@(posedge clk) disable iff (reset) gnt_valid == (|gnt));
  a_idx:    assert property (@(posedge clk) disable iff (reset) gnt_valid |-> (gnt == idx2oh(gnt_idx)));
  a_tmo:    assert property (@(posedge clk) disable iff (reset) timeout |-> $past(gnt_valid));

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority pick: the requester just after last_idx has top priority.
// The candidates are rotated so that requester sits at bit 0, priority-encoded,
// and the offset is added back to recover the absolute index.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] cand,
  input  logic [IW-1:0]   last_idx,
  output logic            win_vld,
  output logic [IW-1:0]   win_idx,
  output logic [NREQ-1:0] win_oh
);

  logic [IW-1:0]     start_s;
  logic [2*NREQ-1:0] dbl_s;
  logic [NREQ-1:0]   rot_s;
  logic [IW-1:0]     off_s;

  assign start_s = last_idx + 2'd1;
  assign dbl_s   = {cand, cand};
  assign rot_s   = dbl_s[start_s +: NREQ];

  // Priority-encode the rotated vector and translate back to an absolute index.
  always_comb begin
    off_s   = 2'd0;
    win_vld = 1'b1;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: begin
        off_s   = 2'd0;
        win_vld = 1'b0;
      end
    endcase
    if (win_vld) begin
      win_idx = start_s + off_s;
      win_oh  = idx2oh(start_s + off_s);
    end else begin
      win_idx = 2'd0;
      win_oh  = 4'b0000;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a per-tenure hold limit and a
// shared DW-bit data mux steered by the registered grant.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int DW       = 2,
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]    gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_valid,
  output logic [DW-1:0]      dout,
  output logic               timeout
);

  state_t          state_r, state_n;
  logic [NREQ-1:0] gnt_r, gnt_n;
  logic [IW-1:0]   gnt_idx_r, gnt_idx_n;
  logic [IW-1:0]   last_idx_r, last_idx_n;
  logic [CW-1:0]   hold_cnt_r, hold_cnt_n;
  logic            timeout_r, timeout_n;

  logic            owner_req_s;
  logic            at_limit_s;
  logic [NREQ-1:0] cand_s;
  logic [IW-1:0]   pick_last_s;
  logic            win_vld_s;
  logic [IW-1:0]   win_idx_s;
  logic [NREQ-1:0] win_oh_s;

  // In BUSY the current owner is masked out and becomes the new rotation
  // origin, so a releasing owner can never win back-to-back over a waiter.
  assign owner_req_s = req[gnt_idx_r];
  assign at_limit_s  = (MAX_HOLD != 0) && (hold_cnt_r == CW'(MAX_HOLD));
  assign cand_s      = (state_r == ST_BUSY) ? (req & ~gnt_r) : req;
  assign pick_last_s = (state_r == ST_BUSY) ? gnt_idx_r : last_idx_r;

  rr_pick u_pick (
    .cand     (cand_s),
    .last_idx (pick_last_s),
    .win_vld  (win_vld_s),
    .win_idx  (win_idx_s),
    .win_oh   (win_oh_s)
  );

  // Next-state, grant, hold counter and timeout decisions.
  always_comb begin
    state_n    = state_r;
    gnt_n      = gnt_r;
    gnt_idx_n  = gnt_idx_r;
    last_idx_n = last_idx_r;
    hold_cnt_n = hold_cnt_r;
    timeout_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_vld_s) begin
          state_n    = ST_BUSY;
          gnt_n      = win_oh_s;
          gnt_idx_n  = win_idx_s;
          hold_cnt_n = {{(CW-1){1'b0}}, 1'b1};
        end else begin
          state_n    = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (owner_req_s && !at_limit_s) begin
          if (hold_cnt_r != {CW{1'b1}}) begin
            hold_cnt_n = hold_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            hold_cnt_n = hold_cnt_r;
          end
        end else begin
          last_idx_n = gnt_idx_r;
          timeout_n  = owner_req_s;
          if (win_vld_s) begin
            gnt_n      = win_oh_s;
            gnt_idx_n  = win_idx_s;
            hold_cnt_n = {{(CW-1){1'b0}}, 1'b1};
          end else begin
            state_n    = ST_IDLE;
            gnt_n      = 4'b0000;
            gnt_idx_n  = 2'd0;
            hold_cnt_n = {CW{1'b0}};
          end
        end
      end
      default: begin
        state_n    = ST_IDLE;
        gnt_n      = 4'b0000;
        gnt_idx_n  = 2'd0;
        hold_cnt_n = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      gnt_r      <= 4'b0000;
      gnt_idx_r  <= 2'd0;
      last_idx_r <= 2'd3;
      hold_cnt_r <= {CW{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      gnt_r      <= gnt_n;
      gnt_idx_r  <= gnt_idx_n;
      last_idx_r <= last_idx_n;
      hold_cnt_r <= hold_cnt_n;
      timeout_r  <= timeout_n;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = |gnt_r;
  assign timeout   = timeout_r;
  assign dout      = gnt_valid ? din[gnt_idx_r*DW +: DW] : {DW{1'b0}};

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench: two arbiters (hold limit 8 and unlimited) compared
// every cycle against a behavioural round-robin model.
module tb_rr_arbiter4;
  localparam int DW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset0, reset1;
  logic [3:0]      req0, req1;
  logic [4*DW-1:0] din0, din1;
  logic [3:0]      gnt0, gnt1;
  logic [1:0]      idx0, idx1;
  logic            vld0, vld1, to0, to1;
  logic [DW-1:0]   dout0, dout1;

  rr_arbiter4 #(.DW(DW), .MAX_HOLD(8), .CW(4)) dut0 (
    .clk(clk), .reset(reset0), .req(req0), .din(din0), .gnt(gnt0),
    .gnt_idx(idx0), .gnt_valid(vld0), .dout(dout0), .timeout(to0));
  rr_arbiter4 #(.DW(DW), .MAX_HOLD(0), .CW(4)) dut1 (
    .clk(clk), .reset(reset1), .req(req1), .din(din1), .gnt(gnt1),
    .gnt_idx(idx1), .gnt_valid(vld1), .dout(dout1), .timeout(to1));

  rr_arbiter4_chk chk0 (.clk(clk), .reset(reset0), .gnt(gnt0), .gnt_idx(idx0),
                        .gnt_valid(vld0), .timeout(to0));
  rr_arbiter4_chk chk1 (.clk(clk), .reset(reset1), .gnt(gnt1), .gnt_idx(idx1),
                        .gnt_valid(vld1), .timeout(to1));

  int n_asserts = 0;
  int n_fail    = 0;

  // Model state: owner (-1 = nobody), tenure length, rotation origin, pulse.
  int own[2];
  int cnt[2];
  int last[2];
  bit to_m[2];
  int mh[2] = '{8, 0};

  function automatic int pick(logic [3:0] c, int l);
    for (int o = 1; o <= 4; o++) begin
      if (c[(l + o) % 4]) return (l + o) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int m, input logic rst, input logic [3:0] rq);
    int k;
    logic [3:0] msk;
    if (rst) begin
      own[m] = -1; cnt[m] = 0; last[m] = 3; to_m[m] = 1'b0;
    end else if (own[m] < 0) begin
      to_m[m] = 1'b0;
      if (rq != 4'b0000) begin
        own[m] = pick(rq, last[m]);
        cnt[m] = 1;
      end
    end else begin
      k = own[m];
      if (rq[k] && (mh[m] == 0 || cnt[m] < mh[m])) begin
        to_m[m] = 1'b0;
        if (cnt[m] < 15) cnt[m]++;
      end else begin
        to_m[m] = rq[k];
        last[m] = k;
        msk = rq;
        msk[k] = 1'b0;
        own[m] = pick(msk, last[m]);
        cnt[m] = (own[m] >= 0) ? 1 : 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_one(input int m, input logic [3:0] g, input logic [1:0] i,
                           input logic v, input logic [DW-1:0] d, input logic t,
                           input logic [4*DW-1:0] dn);
    logic [3:0]    eg;
    logic [DW-1:0] ed;
    eg = 4'b0000;
    ed = '0;
    if (own[m] >= 0) begin
      eg[own[m]] = 1'b1;
      ed = dn[own[m]*DW +: DW];
    end
    chk($sformatf("dut%0d_gnt", m), 32'(g), 32'(eg));
    chk($sformatf("dut%0d_idx", m), 32'(i), (own[m] >= 0) ? own[m] : 0);
    chk($sformatf("dut%0d_valid", m), 32'(v), 32'(own[m] >= 0));
    chk($sformatf("dut%0d_dout", m), 32'(d), 32'(ed));
    chk($sformatf("dut%0d_timeout", m), 32'(t), 32'(to_m[m]));
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later,
  // return at the falling edge ready for new inputs.
  task automatic tick();
    @(posedge clk);
    model_step(0, reset0, req0);
    model_step(1, reset1, req1);
    #1;
    check_one(0, gnt0, idx0, vld0, dout0, to0, din0);
    check_one(1, gnt1, idx1, vld1, dout1, to1, din1);
    @(negedge clk);
  endtask

  task automatic rnd_din();
    din0 = 8'($urandom);
    din1 = 8'($urandom);
  endtask

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    req0 = 4'b0000; req1 = 4'b0000;
    din0 = 8'h00; din1 = 8'h00;
    for (int m = 0; m < 2; m++) begin
      own[m] = -1; cnt[m] = 0; last[m] = 3; to_m[m] = 1'b0;
    end
    @(negedge clk);
    tick();
    tick();
    chk("reset_gnt", 32'(gnt0), 32'h0);
    reset0 = 1'b0; reset1 = 1'b0;

    // All four requesting with a hold limit of 8; dut1 holds requester 0 unlimited.
    req0 = 4'b1111; req1 = 4'b0001;
    tick();
    chk("plan_first_gnt", 32'(gnt0), 32'h1);
    repeat (34) begin rnd_din(); tick(); end
    req0 = 4'b0000;
    tick(); tick();
    chk("plan_unlimited_gnt", 32'(gnt1), 32'h1);

    // Lone requester 2 for three cycles, then gone.
    req0 = 4'b0100;
    repeat (3) begin rnd_din(); tick(); end
    chk("plan_gnt_0100", 32'(gnt0), 32'h4);
    req0 = 4'b0000;
    tick(); tick();
    chk("plan_idle_after_0100", 32'(gnt0), 32'h0);

    // Owner 0 drops while 1 and 3 rise together: 1 wins, then 3.
    req0 = 4'b0001;
    tick(); tick();
    req0 = 4'b1010;
    tick();
    chk("plan_handover_1", 32'(gnt0), 32'h2);
    tick();
    req0 = 4'b1000;
    tick();
    chk("plan_handover_3", 32'(gnt0), 32'h8);
    req0 = 4'b0000;
    tick();

    // Wrap-around from last_idx=3: 0 first, then forced release hands to 3.
    req0 = 4'b1001;
    tick();
    chk("plan_wrap_0", 32'(gnt0), 32'h1);
    repeat (10) begin rnd_din(); tick(); end
    chk("plan_wrap_3", 32'(gnt0), 32'h8);
    req0 = 4'b0000;
    tick();

    // Reset in the middle of a tenure.
    req0 = 4'b0010;
    repeat (5) tick();
    reset0 = 1'b1;
    tick();
    chk("plan_midreset_gnt", 32'(gnt0), 32'h0);
    chk("plan_midreset_tmo", 32'(to0), 32'h0);
    reset0 = 1'b0;
    req0 = 4'b1111;
    tick();
    chk("plan_after_reset_gnt", 32'(gnt0), 32'h1);
    req1 = 4'b0000;
    tick();

    // Randomised traffic with occasional resets.
    repeat (600) begin
      req0 = req0 ^ (4'($urandom) & 4'($urandom));
      req1 = req1 ^ (4'($urandom) & 4'($urandom));
      reset0 = ($urandom_range(0, 59) == 0);
      reset1 = ($urandom_range(0, 59) == 0);
      rnd_din();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
